// File: rtl/seg7_scan_driver.sv
// Four-digit hex scanner for a common-anode 7-segment display, with double-buffered
// value updates, leading-zero suppression, per-digit decimal points and PWM dimming.
module seg7_scan_driver #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int DUTY_BITS  = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [15:0]          value,
    input  logic [3:0]           dp_in,
    input  logic                 blank_lz,
    input  logic [DUTY_BITS-1:0] brightness,
    output logic                 ready,
    output logic                 frame_tick,
    output logic [6:0]           segs,
    output logic                 dp,
    output logic [3:0]           an
);

    localparam int DIG_PERIOD = CLK_FREQ / REFRESH_HZ;
    localparam int CW         = (DIG_PERIOD > 2) ? $clog2(DIG_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIG_PERIOD - 1);

    if (DIG_PERIOD < 2 || DIG_PERIOD < (1 << DUTY_BITS)) begin : g_bad_params
        $fatal(1, "seg7_scan_driver: DIG_PERIOD must be >= 2 and >= 2**DUTY_BITS");
    end

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   shadow_val, pend_val;
    logic [3:0]    shadow_dp, pend_dp;

    logic       term, wrap, en, blank;
    logic [3:0] nib, zero_above;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;  default: decode = 7'h0E;
        endcase
    endfunction

    always_comb begin
        term = (cnt == CNT_LAST);
        wrap = term && (idx == 2'd3);
        // Blank the first cycle of each slot so the previous digit never ghosts.
        en   = (cnt != '0) && (cnt[DUTY_BITS-1:0] <= brightness);
        nib  = shadow_val[{idx, 2'b00} +: 4];
        zero_above[3] = (shadow_val[15:12] == 4'h0);
        zero_above[2] = zero_above[3] && (shadow_val[11:8] == 4'h0);
        zero_above[1] = zero_above[2] && (shadow_val[7:4] == 4'h0);
        zero_above[0] = 1'b0;
        blank = blank_lz && zero_above[idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            idx        <= '0;
            frame_tick <= 1'b0;
            ready      <= 1'b1;
            pend_val   <= '0;
            pend_dp    <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            segs       <= 7'h7F;
            dp         <= 1'b1;
            an         <= 4'hF;
        end else begin
            if (term) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            frame_tick <= wrap;

            // A load accepted on the wrap edge itself waits for the next frame.
            if (wrap && !ready) begin
                shadow_val <= pend_val;
                shadow_dp  <= pend_dp;
                ready      <= 1'b1;
            end else if (load && ready) begin
                pend_val <= value;
                pend_dp  <= dp_in;
                ready    <= 1'b0;
            end

            segs <= blank ? 7'h7F : decode(nib);
            dp   <= ~shadow_dp[idx];
            an   <= en ? ~(4'b0001 << idx) : 4'hF;
        end
    end

endmodule
